// File: rtl/rv_pkg.sv
// Shared architectural widths for the RV memory subsystem.
package rv_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
endpackage

// File: rtl/rv_mem_arbiter_if.sv
// Request/response bundle around rv_mem_arbiter: instruction port, data port and memory port.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface rv_mem_arbiter_if;
  import rv_pkg::*;

  logic            instr_valid_i;
  logic [XLEN-1:0] instr_addr_i;
  logic [ILEN-1:0] instr_rdata_o;
  logic            instr_ready_o;
  logic            instr_err_o;

  logic            data_valid_i;
  logic [XLEN-1:0] data_addr_i;
  logic [XLEN-1:0] data_wdata_i;
  logic            data_write_i;
  logic [XLEN-1:0] data_rdata_o;
  logic            data_ready_o;
  logic            data_err_o;

  logic            mem_valid_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic            mem_write_o;
  logic [XLEN-1:0] mem_rdata_i;
  logic            mem_ready_i;

  modport slave (
    input  instr_valid_i, instr_addr_i,
    output instr_rdata_o, instr_ready_o, instr_err_o,
    input  data_valid_i, data_addr_i, data_wdata_i, data_write_i,
    output data_rdata_o, data_ready_o, data_err_o,
    output mem_valid_o, mem_addr_o, mem_wdata_o, mem_write_o,
    input  mem_rdata_i, mem_ready_i
  );

  modport master (
    output instr_valid_i, instr_addr_i,
    input  instr_rdata_o, instr_ready_o, instr_err_o,
    output data_valid_i, data_addr_i, data_wdata_i, data_write_i,
    input  data_rdata_o, data_ready_o, data_err_o,
    input  mem_valid_o, mem_addr_o, mem_wdata_o, mem_write_o,
    output mem_rdata_i, mem_ready_i
  );
endinterface

// File: rtl/rv_mem_arbiter.sv
// Two-port (instr/data) to single memory port arbiter with IDLE/BUSY/RESP FSM and access timeout.
// Define RV_ARB_RR_EN for round-robin contention handling; otherwise data has fixed priority.
module rv_mem_arbiter
  import rv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  rv_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT_CYCLES);

  state_e          state_r;
  logic            grant_data_r;
  logic [7:0]      cnt_r;
  logic            mem_valid_r;
  logic            mem_write_r;
  logic [XLEN-1:0] mem_addr_r;
  logic [XLEN-1:0] mem_wdata_r;
  logic            instr_ready_r;
  logic            instr_err_r;
  logic [ILEN-1:0] instr_rdata_r;
  logic            data_ready_r;
  logic            data_err_r;
  logic [XLEN-1:0] data_rdata_r;
  logic            any_req_s;
  logic            pick_data_s;
`ifdef RV_ARB_RR_EN
  logic            last_grant_data_r;
`endif

  // Pick which requester wins if a grant happens this cycle
  always_comb begin
    any_req_s   = bus.instr_valid_i | bus.data_valid_i;
    pick_data_s = 1'b0;
`ifdef RV_ARB_RR_EN
    if (bus.instr_valid_i && bus.data_valid_i) begin
      pick_data_s = ~last_grant_data_r;
    end else begin
      pick_data_s = bus.data_valid_i;
    end
`else
    pick_data_s = bus.data_valid_i;
`endif
  end

  // Arbiter FSM; every output is a register updated here
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= ST_IDLE;
      grant_data_r  <= 1'b1;
      cnt_r         <= 8'd0;
      mem_valid_r   <= 1'b0;
      mem_write_r   <= 1'b0;
      mem_addr_r    <= {XLEN{1'b0}};
      mem_wdata_r   <= {XLEN{1'b0}};
      instr_ready_r <= 1'b0;
      instr_err_r   <= 1'b0;
      instr_rdata_r <= {ILEN{1'b0}};
      data_ready_r  <= 1'b0;
      data_err_r    <= 1'b0;
      data_rdata_r  <= {XLEN{1'b0}};
`ifdef RV_ARB_RR_EN
      last_grant_data_r <= 1'b1;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            grant_data_r <= pick_data_s;
            cnt_r        <= 8'd0;
            mem_valid_r  <= 1'b1;
            state_r      <= ST_BUSY;
`ifdef RV_ARB_RR_EN
            last_grant_data_r <= pick_data_s;
`endif
            if (pick_data_s) begin
              mem_addr_r  <= bus.data_addr_i;
              mem_wdata_r <= bus.data_wdata_i;
              mem_write_r <= bus.data_write_i;
            end else begin
              mem_addr_r  <= bus.instr_addr_i;
              mem_wdata_r <= {XLEN{1'b0}};
              mem_write_r <= 1'b0;
            end
          end
        end
        ST_BUSY: begin
          // A ready arriving on the final counted cycle still wins over the timeout
          if (bus.mem_ready_i) begin
            mem_valid_r <= 1'b0;
            state_r     <= ST_RESP;
            if (grant_data_r) begin
              data_ready_r <= 1'b1;
              data_rdata_r <= bus.mem_rdata_i;
            end else begin
              instr_ready_r <= 1'b1;
              instr_rdata_r <= bus.mem_rdata_i;
            end
          end else if ((cnt_r + 8'd1) == TIMEOUT_C) begin
            mem_valid_r <= 1'b0;
            state_r     <= ST_RESP;
            if (grant_data_r) begin
              data_ready_r <= 1'b1;
              data_err_r   <= 1'b1;
              data_rdata_r <= {XLEN{1'b0}};
            end else begin
              instr_ready_r <= 1'b1;
              instr_err_r   <= 1'b1;
              instr_rdata_r <= {ILEN{1'b0}};
            end
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        ST_RESP: begin
          instr_ready_r <= 1'b0;
          instr_err_r   <= 1'b0;
          data_ready_r  <= 1'b0;
          data_err_r    <= 1'b0;
          state_r       <= ST_IDLE;
        end
        default: begin
          mem_valid_r   <= 1'b0;
          instr_ready_r <= 1'b0;
          instr_err_r   <= 1'b0;
          data_ready_r  <= 1'b0;
          data_err_r    <= 1'b0;
          state_r       <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_valid_o   = mem_valid_r;
  assign bus.mem_write_o   = mem_write_r;
  assign bus.mem_addr_o    = mem_addr_r;
  assign bus.mem_wdata_o   = mem_wdata_r;
  assign bus.instr_ready_o = instr_ready_r;
  assign bus.instr_err_o   = instr_err_r;
  assign bus.instr_rdata_o = instr_rdata_r;
  assign bus.data_ready_o  = data_ready_r;
  assign bus.data_err_o    = data_err_r;
  assign bus.data_rdata_o  = data_rdata_r;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed self-checking bench for rv_mem_arbiter with a behavioural word memory.
// Expectations follow RV_ARB_RR_EN the same way the design does.
module tb_rv_mem_arbiter;
  import rv_pkg::*;

`ifdef RV_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rv_mem_arbiter_if bus ();

  rv_mem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem_q [0:255];
  int          mem_wait;
  bit          mem_stall;
  int          instr_pulses;
  int          data_pulses;
  int          valid_cycles;
  bit          grant_q [$];

  // Memory model: answers mem_wait cycles after mem_valid_o is seen, never while stalled
  initial begin
    int resp_cnt;
    resp_cnt = 0;
    for (int i = 0; i < 256; i++) mem_q[i] = 32'h1000_0000 | 32'(i);
    mem_q[8'h25] = 32'h0000_0013;
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      if (bus.mem_valid_o === 1'b1 && !mem_stall) begin
        if (resp_cnt >= mem_wait) begin
          bus.mem_ready_i = 1'b1;
          if (bus.mem_write_o === 1'b1) begin
            mem_q[bus.mem_addr_o[7:0]] = bus.mem_wdata_o;
            bus.mem_rdata_i = bus.mem_wdata_o;
          end else begin
            bus.mem_rdata_i = mem_q[bus.mem_addr_o[7:0]];
          end
          resp_cnt = 0;
        end else begin
          bus.mem_ready_i = 1'b0;
          bus.mem_rdata_i = 32'hBAD0_BAD0;
          resp_cnt++;
        end
      end else begin
        bus.mem_ready_i = 1'b0;
        bus.mem_rdata_i = 32'hBAD0_BAD0;
        resp_cnt = 0;
      end
    end
  end

  // Monitor: counts ready pulses, grant order and cycles with mem_valid_o high
  initial begin
    instr_pulses = 0;
    data_pulses  = 0;
    valid_cycles = 0;
    forever begin
      @(negedge clk);
      #1;
      if (bus.instr_ready_o === 1'b1) begin instr_pulses++; grant_q.push_back(1'b0); end
      if (bus.data_ready_o === 1'b1) begin data_pulses++; grant_q.push_back(1'b1); end
      if (bus.mem_valid_o === 1'b1) valid_cycles++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_resp(input int budget, output bit seen, output int cyc);
    seen = 1'b0;
    cyc  = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      cyc++;
      if (bus.instr_ready_o === 1'b1 || bus.data_ready_o === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic clear_inputs();
    bus.instr_valid_i = 1'b0;
    bus.instr_addr_i  = 32'h0;
    bus.data_valid_i  = 1'b0;
    bus.data_addr_i   = 32'h0;
    bus.data_wdata_i  = 32'h0;
    bus.data_write_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.instr_valid_i = 1'b1;
    bus.data_valid_i  = 1'b1;
    bus.data_write_i  = 1'b1;
    bus.data_wdata_i  = 32'hFFFF_FFFF;
    tick();
    tick();
    checks++; if (bus.mem_valid_o !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got %0h exp 0", bus.mem_valid_o); end
    checks++; if (bus.mem_write_o !== 1'b0) begin errors++; $display("FAIL reset_mem_write got %0h exp 0", bus.mem_write_o); end
    checks++; if (bus.mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %0h exp 0", bus.mem_addr_o); end
    checks++; if (bus.mem_wdata_o !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %0h exp 0", bus.mem_wdata_o); end
    checks++; if ({bus.instr_ready_o, bus.data_ready_o} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", {bus.instr_ready_o, bus.data_ready_o}); end
    checks++; if ({bus.instr_err_o, bus.data_err_o} !== 2'b00) begin errors++; $display("FAIL reset_err got %b exp 00", {bus.instr_err_o, bus.data_err_o}); end
    checks++; if (bus.instr_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_instr_rdata got %0h exp 0", bus.instr_rdata_o); end
    checks++; if (bus.data_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_data_rdata got %0h exp 0", bus.data_rdata_o); end
    clear_inputs();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_instr_fetch();
    bit seen;
    int cyc;
    int p0;
    p0 = instr_pulses;
    bus.instr_valid_i = 1'b1;
    bus.instr_addr_i  = 32'h0000_4025;
    tick();
    checks++; if (bus.mem_valid_o !== 1'b1) begin errors++; $display("FAIL ifetch_mem_valid got %0h exp 1", bus.mem_valid_o); end
    checks++; if (bus.mem_addr_o !== 32'h0000_4025) begin errors++; $display("FAIL ifetch_mem_addr got %0h exp 4025", bus.mem_addr_o); end
    checks++; if (bus.mem_write_o !== 1'b0) begin errors++; $display("FAIL ifetch_mem_write got %0h exp 0", bus.mem_write_o); end
    checks++; if (bus.mem_wdata_o !== 32'h0) begin errors++; $display("FAIL ifetch_mem_wdata got %0h exp 0", bus.mem_wdata_o); end
    bus.instr_valid_i = 1'b0;
    wait_resp(10, seen, cyc);
    checks++; if (seen !== 1'b1 || bus.instr_ready_o !== 1'b1) begin errors++; $display("FAIL ifetch_ready got %0h exp 1", bus.instr_ready_o); end
    checks++; if ((cyc + 1) != 2) begin errors++; $display("FAIL ifetch_latency got %0d exp 2", cyc + 1); end
    checks++; if (bus.instr_rdata_o !== 32'h0000_0013) begin errors++; $display("FAIL ifetch_rdata got %0h exp 13", bus.instr_rdata_o); end
    checks++; if (bus.instr_err_o !== 1'b0 || bus.data_ready_o !== 1'b0) begin errors++; $display("FAIL ifetch_err_or_dready got %b exp 00", {bus.instr_err_o, bus.data_ready_o}); end
    tick();
    checks++; if (bus.instr_ready_o !== 1'b0) begin errors++; $display("FAIL ifetch_pulse_end got %0h exp 0", bus.instr_ready_o); end
    checks++; if (instr_pulses - p0 != 1) begin errors++; $display("FAIL ifetch_pulse_count got %0d exp 1", instr_pulses - p0); end
  endtask

  task automatic test_write_read();
    bit seen;
    int cyc;
    int d0;
    d0 = data_pulses;
    bus.data_valid_i = 1'b1;
    bus.data_addr_i  = 32'h3;
    bus.data_wdata_i = 32'h2A7;
    bus.data_write_i = 1'b1;
    tick();
    checks++; if (bus.mem_write_o !== 1'b1) begin errors++; $display("FAIL wr_mem_write got %0h exp 1", bus.mem_write_o); end
    checks++; if (bus.mem_wdata_o !== 32'h2A7) begin errors++; $display("FAIL wr_mem_wdata got %0h exp 2a7", bus.mem_wdata_o); end
    checks++; if (bus.mem_addr_o !== 32'h3) begin errors++; $display("FAIL wr_mem_addr got %0h exp 3", bus.mem_addr_o); end
    clear_inputs();
    wait_resp(10, seen, cyc);
    checks++; if (seen !== 1'b1 || bus.data_ready_o !== 1'b1) begin errors++; $display("FAIL wr_ready got %0h exp 1", bus.data_ready_o); end
    checks++; if (bus.data_rdata_o !== 32'h2A7) begin errors++; $display("FAIL wr_rdata_echo got %0h exp 2a7", bus.data_rdata_o); end
    checks++; if (bus.instr_rdata_o !== 32'h13) begin errors++; $display("FAIL wr_instr_rdata_hold got %0h exp 13", bus.instr_rdata_o); end
    tick();
    checks++; if (data_pulses - d0 != 1) begin errors++; $display("FAIL wr_pulse_count got %0d exp 1", data_pulses - d0); end
    bus.data_valid_i = 1'b1;
    bus.data_addr_i  = 32'h3;
    bus.data_wdata_i = 32'hFFFF_FFFF;
    bus.data_write_i = 1'b0;
    tick();
    checks++; if (bus.mem_write_o !== 1'b0) begin errors++; $display("FAIL rd_mem_write got %0h exp 0", bus.mem_write_o); end
    clear_inputs();
    wait_resp(10, seen, cyc);
    checks++; if (seen !== 1'b1 || bus.data_rdata_o !== 32'h2A7) begin errors++; $display("FAIL rd_rdata got %0h exp 2a7", bus.data_rdata_o); end
    checks++; if (bus.data_err_o !== 1'b0) begin errors++; $display("FAIL rd_err got %0h exp 0", bus.data_err_o); end
    tick();
  endtask

  task automatic test_contention();
    int g0;
    int i0;
    bit exp_data;
    g0 = grant_q.size();
    i0 = instr_pulses;
    bus.instr_valid_i = 1'b1;
    bus.instr_addr_i  = 32'h40;
    bus.data_valid_i  = 1'b1;
    bus.data_addr_i   = 32'h41;
    bus.data_write_i  = 1'b0;
    for (int i = 0; i < 40 && grant_q.size() < g0 + 4; i++) tick();
    clear_inputs();
    checks++; if (grant_q.size() != g0 + 4) begin errors++; $display("FAIL cont_grant_count got %0d exp 4", grant_q.size() - g0); end
    if (grant_q.size() >= g0 + 4) begin
      for (int k = 0; k < 4; k++) begin
        exp_data = RR_EN ? ((k % 2) == 1) : 1'b1;
        checks++; if (grant_q[g0 + k] !== exp_data) begin errors++; $display("FAIL cont_grant_%0d got %0d exp %0d", k, grant_q[g0 + k], exp_data); end
      end
    end
    checks++; if (instr_pulses - i0 != (RR_EN ? 2 : 0)) begin errors++; $display("FAIL cont_instr_pulses got %0d exp %0d", instr_pulses - i0, RR_EN ? 2 : 0); end
    tick();
    tick();
  endtask

  task automatic test_timeout();
    bit seen;
    int cyc;
    int v0;
    mem_stall = 1'b1;
    v0 = valid_cycles;
    bus.data_valid_i = 1'b1;
    bus.data_addr_i  = 32'h5;
    tick();
    clear_inputs();
    wait_resp(40, seen, cyc);
    checks++; if (seen !== 1'b1 || bus.data_ready_o !== 1'b1) begin errors++; $display("FAIL to_ready got %0h exp 1", bus.data_ready_o); end
    checks++; if (bus.data_err_o !== 1'b1) begin errors++; $display("FAIL to_err got %0h exp 1", bus.data_err_o); end
    checks++; if (bus.data_rdata_o !== 32'h0) begin errors++; $display("FAIL to_rdata got %0h exp 0", bus.data_rdata_o); end
    checks++; if (valid_cycles - v0 != 16) begin errors++; $display("FAIL to_valid_cycles got %0d exp 16", valid_cycles - v0); end
    tick();
    checks++; if (bus.data_err_o !== 1'b0) begin errors++; $display("FAIL to_err_clear got %0h exp 0", bus.data_err_o); end
    mem_stall = 1'b0;
    bus.data_valid_i = 1'b1;
    bus.data_addr_i  = 32'h5;
    tick();
    clear_inputs();
    wait_resp(10, seen, cyc);
    checks++; if (seen !== 1'b1 || bus.data_err_o !== 1'b0) begin errors++; $display("FAIL to_next_err got %0h exp 0", bus.data_err_o); end
    checks++; if (bus.data_rdata_o !== 32'h1000_0005) begin errors++; $display("FAIL to_next_rdata got %0h exp 10000005", bus.data_rdata_o); end
    tick();
  endtask

  task automatic test_timeout_edge();
    bit seen;
    int cyc;
    int v0;
    mem_wait = 15;
    v0 = valid_cycles;
    bus.data_valid_i = 1'b1;
    bus.data_addr_i  = 32'h6;
    tick();
    clear_inputs();
    wait_resp(40, seen, cyc);
    checks++; if (seen !== 1'b1 || bus.data_err_o !== 1'b0) begin errors++; $display("FAIL toedge_err got %0h exp 0", bus.data_err_o); end
    checks++; if (bus.data_rdata_o !== 32'h1000_0006) begin errors++; $display("FAIL toedge_rdata got %0h exp 10000006", bus.data_rdata_o); end
    checks++; if (valid_cycles - v0 != 16) begin errors++; $display("FAIL toedge_valid_cycles got %0d exp 16", valid_cycles - v0); end
    mem_wait = 0;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    int d0;
    int i0;
    int g0;
    mem_stall = 1'b1;
    d0 = data_pulses;
    i0 = instr_pulses;
    bus.data_valid_i = 1'b1;
    bus.data_addr_i  = 32'h7;
    tick();
    clear_inputs();
    tick();
    tick();
    checks++; if (bus.mem_valid_o !== 1'b1) begin errors++; $display("FAIL rstbusy_pre_valid got %0h exp 1", bus.mem_valid_o); end
    rst = 1'b1;
    tick();
    checks++; if (bus.mem_valid_o !== 1'b0) begin errors++; $display("FAIL rstbusy_valid got %0h exp 0", bus.mem_valid_o); end
    rst = 1'b0;
    mem_stall = 1'b0;
    tick();
    tick();
    checks++; if (data_pulses != d0 || instr_pulses != i0) begin errors++; $display("FAIL rstbusy_no_pulse got %0d exp 0", (data_pulses - d0) + (instr_pulses - i0)); end
    g0 = grant_q.size();
    bus.instr_valid_i = 1'b1;
    bus.instr_addr_i  = 32'h50;
    bus.data_valid_i  = 1'b1;
    bus.data_addr_i   = 32'h51;
    for (int i = 0; i < 20 && grant_q.size() <= g0; i++) tick();
    clear_inputs();
    checks++; if (grant_q.size() <= g0) begin errors++; $display("FAIL rstbusy_regrant got %0d exp 1", grant_q.size() - g0); end
    if (grant_q.size() > g0) begin
      checks++; if (grant_q[g0] !== !RR_EN) begin errors++; $display("FAIL rstbusy_first_grant got %0d exp %0d", grant_q[g0], !RR_EN); end
    end
    tick();
    tick();
  endtask

  task automatic test_mid_busy_change();
    bit seen;
    bit bad;
    logic [31:0] bad_addr;
    int v0;
    seen = 1'b0;
    bad = 1'b0;
    bad_addr = 32'h10;
    mem_wait = 4;
    v0 = valid_cycles;
    bus.data_valid_i = 1'b1;
    bus.data_addr_i  = 32'h10;
    bus.data_write_i = 1'b0;
    tick();
    bus.data_addr_i  = 32'h20;
    bus.data_write_i = 1'b1;
    bus.data_wdata_i = 32'h5555_5555;
    bus.data_valid_i = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.mem_valid_o === 1'b1 && (bus.mem_addr_o !== 32'h10 || bus.mem_write_o !== 1'b0)) begin
        bad = 1'b1;
        bad_addr = bus.mem_addr_o;
      end
      tick();
      if (bus.data_ready_o === 1'b1) seen = 1'b1;
    end
    clear_inputs();
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL midbusy_addr got %0h exp 10", bad_addr); end
    checks++; if (seen !== 1'b1 || bus.data_rdata_o !== 32'h1000_0010) begin errors++; $display("FAIL midbusy_rdata got %0h exp 10000010", bus.data_rdata_o); end
    checks++; if (valid_cycles - v0 != 5) begin errors++; $display("FAIL midbusy_valid_cycles got %0d exp 5", valid_cycles - v0); end
    mem_wait = 0;
    tick();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    mem_wait  = 0;
    mem_stall = 1'b0;
    rst       = 1'b1;
    clear_inputs();
    test_reset();
    test_instr_fetch();
    test_write_read();
    test_contention();
    test_timeout();
    test_timeout_edge();
    test_reset_mid_busy();
    test_mid_busy_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
